// File: rtl/issue_scoreboard_pkg.sv
// issue_scoreboard_pkg: shared widths, non-writing opcode class and issue-register state encoding.
package issue_scoreboard_pkg;
    localparam int SB_LEN_OPECODE = 7;
    localparam int SB_LEN_REGNO = 4;
    localparam int SB_NUM_REGS = 16;
    localparam int SB_LEN_CNT = 5;
    localparam logic [2:0] SB_NOWR_CLASS = 3'b111;
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;
endpackage

// File: rtl/issue_scoreboard_popcount.sv
// sb_popcount: population count of a reservation vector.
module sb_popcount #(
    parameter int N = 16,
    parameter int W = 5
) (
    input  logic [N-1:0] i_bits,
    output logic [W-1:0] o_cnt
);
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < N; i++) o_cnt = o_cnt + W'(i_bits[i]);
    end
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: in-order single-issue scoreboard with a one-entry issue register.
// Optional ISSUE_SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear a hazard.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int LEN_OPECODE = SB_LEN_OPECODE,
    parameter int LEN_REGNO = SB_LEN_REGNO,
    parameter int NUM_REGS = SB_NUM_REGS,
    parameter int LEN_CNT = SB_LEN_CNT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dec_valid_i,
    output logic                   dec_ready_o,
    input  logic [LEN_OPECODE-1:0] opecode_i,
    input  logic                   immf_i,
    input  logic [LEN_REGNO-1:0]   rd_i,
    input  logic [LEN_REGNO-1:0]   rs_i,
    output logic                   iss_valid_o,
    input  logic                   iss_ready_i,
    output logic [LEN_OPECODE-1:0] iss_opecode_o,
    output logic                   iss_immf_o,
    output logic [LEN_REGNO-1:0]   iss_rd_o,
    output logic [LEN_REGNO-1:0]   iss_rs_o,
    input  logic                   wb_i,
    input  logic [LEN_REGNO-1:0]   wb_r_i,
    input  logic                   flush_i,
    output logic [NUM_REGS-1:0]    busy_o,
    output logic [LEN_CNT-1:0]     inflight_o,
    output logic                   sb_err_o
);
    logic [0:0]             r_state;
    logic [LEN_OPECODE-1:0] r_opc;
    logic                   r_immf;
    logic [LEN_REGNO-1:0]   r_rd;
    logic [LEN_REGNO-1:0]   r_rs;
    logic [NUM_REGS-1:0]    r_busy;
    logic [LEN_CNT-1:0]     r_cnt;
    logic                   r_err;
    logic                   w_valid;
    logic                   w_hazard;
    logic                   w_accept;
    logic                   w_wr_new;
    logic                   w_wr_held;
    logic [NUM_REGS-1:0]    w_busy_chk;
    logic [NUM_REGS-1:0]    w_clr_wb;
    logic [NUM_REGS-1:0]    w_clr_fl;
    logic [NUM_REGS-1:0]    w_set;
    logic [NUM_REGS-1:0]    w_busy_nxt;
    logic [LEN_CNT-1:0]     w_cnt_nxt;

    assign w_valid = (r_state == ST_FULL);
    assign w_wr_new = (opecode_i[LEN_OPECODE-1 -: 3] != SB_NOWR_CLASS);
    assign w_wr_held = (r_opc[LEN_OPECODE-1 -: 3] != SB_NOWR_CLASS);
    assign w_clr_wb = wb_i ? (NUM_REGS'(1) << wb_r_i) : '0;
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
    assign w_busy_chk = r_busy & ~w_clr_wb;
`else
    assign w_busy_chk = r_busy;
`endif
    // rd is always a source too, so this also blocks WAW
    assign w_hazard = w_busy_chk[rd_i] | (!immf_i & w_busy_chk[rs_i]);
    assign dec_ready_o = (!w_valid | iss_ready_i) & !w_hazard & !flush_i & !rst;
    assign w_accept = dec_valid_i & dec_ready_o;
    // a flushed instruction only gives back its reservation if it was not taken
    assign w_clr_fl = (flush_i && w_valid && !iss_ready_i && w_wr_held) ? (NUM_REGS'(1) << r_rd) : '0;
    assign w_set = (w_accept && w_wr_new) ? (NUM_REGS'(1) << rd_i) : '0;
    assign w_busy_nxt = (r_busy & ~(w_clr_wb | w_clr_fl)) | w_set;

    sb_popcount #(.N(NUM_REGS), .W(LEN_CNT)) u_popcount (
        .i_bits(w_busy_nxt),
        .o_cnt (w_cnt_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_opc   <= '0;
            r_immf  <= 1'b0;
            r_rd    <= '0;
            r_rs    <= '0;
            r_busy  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
            if (wb_i && !r_busy[wb_r_i]) r_err <= 1'b1;
            if (flush_i) begin
                r_state <= ST_EMPTY;
            end else if (w_accept) begin
                r_state <= ST_FULL;
                r_opc   <= opecode_i;
                r_immf  <= immf_i;
                r_rd    <= rd_i;
                r_rs    <= rs_i;
            end else if (iss_ready_i) begin
                r_state <= ST_EMPTY;
            end
        end
    end

    assign iss_valid_o = w_valid;
    assign iss_opecode_o = r_opc;
    assign iss_immf_o = r_immf;
    assign iss_rd_o = r_rd;
    assign iss_rs_o = r_rs;
    assign busy_o = r_busy;
    assign inflight_o = r_cnt;
    assign sb_err_o = r_err;
endmodule
